// File: rtl/sprite_fetch.sv
// sprite_fetch: turns the raster position into a sprite ROM address and colour-keys the returned word.
// Define SPRITE_MIRROR_EN to mirror the sprite horizontally when the latched facing bit is set.
module sprite_fetch #(
    parameter int          SPRITE_W  = 60,
    parameter int          SPRITE_H  = 83,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  SpriteX,
    input  logic [9:0]  SpriteY,
    input  logic [2:0]  frame_sel,
    input  logic        facing,
    output logic [18:0] read_address,
    input  logic [23:0] data_Out,
    output logic        pix_out_valid,
    output logic        pix_opaque,
    output logic [23:0] pix_rgb
);

    localparam logic [9:0]  W10        = 10'(SPRITE_W);
    localparam logic [9:0]  H10        = 10'(SPRITE_H);
    localparam logic [18:0] W19        = 19'(SPRITE_W);
    localparam logic [18:0] FRAME_SIZE = 19'(SPRITE_W * SPRITE_H);

    typedef enum logic {DISARMED, ARMED} arm_state_t;

    arm_state_t  arm_state;
    logic [9:0]  x_lat;
    logic [9:0]  y_lat;
    logic        facing_lat;
    logic [18:0] frame_base;
    logic [9:0]  row_idx;
    logic [18:0] row_base;

    logic        v1, inbox1;
    logic        v2, inbox2;

    logic [9:0]  off_x;
    logic [9:0]  off_y;
    logic [9:0]  col;
    logic        in_box;
    logic        row_step;
    logic [18:0] row_base_eff;
    logic [18:0] addr_next;
    logic        unused_facing;

    // Offsets wrap as unsigned, so pixels left of / above the sprite never land in the box.
    always_comb begin
        off_x         = DrawX - x_lat;
        off_y         = DrawY - y_lat;
        in_box        = (arm_state == ARMED) && (off_x < W10) && (off_y < H10);
        row_step      = in_box && (off_y > row_idx);
        row_base_eff  = row_step ? (row_base + W19) : row_base;
        unused_facing = facing_lat;
`ifdef SPRITE_MIRROR_EN
        col           = facing_lat ? (W10 - 10'd1 - off_x) : off_x;
`else
        col           = off_x;
`endif
        addr_next     = frame_base + row_base_eff + {9'd0, col};
    end

    // Stage 1 registers the address; the ROM adds stage 2; stage 3 applies the colour key.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            arm_state     <= DISARMED;
            x_lat         <= '0;
            y_lat         <= '0;
            facing_lat    <= 1'b0;
            frame_base    <= '0;
            row_idx       <= '0;
            row_base      <= '0;
            read_address  <= '0;
            v1            <= 1'b0;
            inbox1        <= 1'b0;
            v2            <= 1'b0;
            inbox2        <= 1'b0;
            pix_out_valid <= 1'b0;
            pix_opaque    <= 1'b0;
            pix_rgb       <= '0;
        end else begin
            if (pix_valid && in_box) begin
                read_address <= addr_next;
                if (row_step) begin
                    row_idx  <= row_idx + 10'd1;
                    row_base <= row_base + W19;
                end
            end

            // Placed after the pixel update so a coinciding pixel uses the old frame's values.
            if (frame_start) begin
                arm_state  <= ARMED;
                x_lat      <= SpriteX;
                y_lat      <= SpriteY;
                facing_lat <= facing;
                frame_base <= FRAME_SIZE * {16'd0, frame_sel};
                row_idx    <= '0;
                row_base   <= '0;
            end

            v1            <= pix_valid;
            inbox1        <= pix_valid && in_box;
            v2            <= v1;
            inbox2        <= inbox1;
            pix_out_valid <= v2;

            if (v2 && inbox2 && (data_Out != KEY_COLOR)) begin
                pix_opaque <= 1'b1;
                pix_rgb    <= data_Out;
            end else begin
                pix_opaque <= 1'b0;
                pix_rgb    <= '0;
            end
        end
    end

endmodule
